// File: rtl/sbox_q2_masked_pipe.sv
// Second-order (3-share) masked quadratic 4-bit S-box G over NUM_SBOX parallel lanes, valid/ready pipelined.
// Optional macro SBOX_OUT_REG_EN adds a registered stage after share compression (latency 2).
module sbox_q2_masked_pipe #(
    parameter int unsigned NUM_SBOX = 16,
    localparam int unsigned SH_W    = 4 * NUM_SBOX,
    localparam int unsigned RND_W   = 18 * NUM_SBOX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SH_W-1:0]  in_sh0,
    input  logic [SH_W-1:0]  in_sh1,
    input  logic [SH_W-1:0]  in_sh2,
    input  logic [RND_W-1:0] rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SH_W-1:0]  out_sh0,
    output logic [SH_W-1:0]  out_sh1,
    output logic [SH_W-1:0]  out_sh2,
    output logic [15:0]      xfer_cnt
);

    // Nine cross-share terms p_i&q_j; linear shares fold into the diagonal; masks XOR to zero overall.
    function automatic logic [8:0] quad_terms(input logic [2:0] p, input logic [2:0] q,
                                              input logic [2:0] lin, input logic [7:0] r);
        logic [8:0] m;
        logic [8:0] t;
        m    = {r[7], r[7:1] ^ r[6:0], r[0]};
        t[0] = (p[0] & q[0]) ^ lin[0] ^ m[0];
        t[1] = (p[0] & q[1]) ^ m[1];
        t[2] = (p[0] & q[2]) ^ m[2];
        t[3] = (p[1] & q[0]) ^ m[3];
        t[4] = (p[1] & q[1]) ^ lin[1] ^ m[4];
        t[5] = (p[1] & q[2]) ^ m[5];
        t[6] = (p[2] & q[0]) ^ m[6];
        t[7] = (p[2] & q[1]) ^ m[7];
        t[8] = (p[2] & q[2]) ^ lin[2] ^ m[8];
        return t;
    endfunction

    // Output share i collects the three registered terms whose left operand is share i.
    function automatic logic [2:0] compress(input logic [8:0] t);
        return {^t[8:6], ^t[5:3], ^t[2:0]};
    endfunction

    logic [NUM_SBOX-1:0][8:0] t2_d, t3_d, t2_q, t3_q;
    logic [NUM_SBOX-1:0][2:0] y0_d, y1_d, y0_q, y1_q;
    logic [SH_W-1:0]          comp_sh0, comp_sh1, comp_sh2;
    logic                     v1;
    logic                     s1_load;
    logic                     s1_adv;

    for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
        logic [2:0] a, b, c, d;
        logic [2:0] y2_sh, y3_sh;
        logic [7:0] r2, r3;
        logic [1:0] rl;

        assign a  = {in_sh2[4*l],   in_sh1[4*l],   in_sh0[4*l]};
        assign b  = {in_sh2[4*l+1], in_sh1[4*l+1], in_sh0[4*l+1]};
        assign c  = {in_sh2[4*l+2], in_sh1[4*l+2], in_sh0[4*l+2]};
        assign d  = {in_sh2[4*l+3], in_sh1[4*l+3], in_sh0[4*l+3]};
        assign r2 = rnd[18*l +: 8];
        assign r3 = rnd[18*l+8 +: 8];
        assign rl = rnd[18*l+16 +: 2];

        assign t2_d[l] = quad_terms(b, d, a ^ c, r2);
        assign t3_d[l] = quad_terms(c, d, b, r3);
        // Linear bits: one fresh bit added to two shares keeps the sharing uniform.
        assign y0_d[l] = c ^ {1'b0, rl[0], rl[0]};
        assign y1_d[l] = (c ^ d) ^ {1'b0, rl[1], rl[1]};

        assign y2_sh = compress(t2_q[l]);
        assign y3_sh = compress(t3_q[l]);
        assign comp_sh0[4*l +: 4] = {y3_sh[0], y2_sh[0], y1_q[l][0], y0_q[l][0]};
        assign comp_sh1[4*l +: 4] = {y3_sh[1], y2_sh[1], y1_q[l][1], y0_q[l][1]};
        assign comp_sh2[4*l +: 4] = {y3_sh[2], y2_sh[2], y1_q[l][2], y0_q[l][2]};
    end

    assign s1_load = in_valid & in_ready;

    // Term registers: load only on an accepted input, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            t2_q <= '0;
            t3_q <= '0;
            y0_q <= '0;
            y1_q <= '0;
        end else if (s1_load) begin
            v1   <= 1'b1;
            t2_q <= t2_d;
            t3_q <= t3_d;
            y0_q <= y0_d;
            y1_q <= y1_d;
        end else if (s1_adv) begin
            v1   <= 1'b0;
        end
    end

`ifdef SBOX_OUT_REG_EN
    logic v2;

    assign s1_adv    = !v2 | out_ready;
    assign in_ready  = !rst & !(v1 & v2 & !out_ready);
    assign out_valid = v2;

    // Compressed shares move into the output stage whenever it is empty or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            out_sh0 <= '0;
            out_sh1 <= '0;
            out_sh2 <= '0;
        end else if (v1 && s1_adv) begin
            v2      <= 1'b1;
            out_sh0 <= comp_sh0;
            out_sh1 <= comp_sh1;
            out_sh2 <= comp_sh2;
        end else if (out_ready) begin
            v2      <= 1'b0;
        end
    end
`else
    assign s1_adv    = out_ready;
    assign in_ready  = !rst & (!v1 | out_ready);
    assign out_valid = v1;
    assign out_sh0   = comp_sh0;
    assign out_sh1   = comp_sh1;
    assign out_sh2   = comp_sh2;
`endif

    // Completed output transfers, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sbox_q2_masked_pipe.sv
// Directed self-checking bench for sbox_q2_masked_pipe (16 lanes), latency-aware for SBOX_OUT_REG_EN.
module tb_sbox_q2_masked_pipe;

    localparam int unsigned NUM_SBOX = 16;
    localparam int unsigned W        = 4 * NUM_SBOX;
    localparam int unsigned RW       = 18 * NUM_SBOX;
`ifdef SBOX_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_sh0, in_sh1, in_sh2;
    logic [RW-1:0] rnd;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sh0, out_sh1, out_sh2;
    logic [15:0]   xfer_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt;
    logic [W-1:0] exp_tbl [1000];

    sbox_q2_masked_pipe #(.NUM_SBOX(NUM_SBOX)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sh0(in_sh0), .in_sh1(in_sh1), .in_sh2(in_sh2),
        .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sh0(out_sh0), .out_sh1(out_sh1), .out_sh2(out_sh2),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] g(input logic [3:0] x);
        logic a, b, c, d;
        {d, c, b, a} = x;
        return {b ^ (c & d), a ^ (b & d) ^ c, c ^ d, c};
    endfunction

    function automatic logic [W-1:0] g_all(input logic [W-1:0] x);
        logic [W-1:0] y;
        for (int k = 0; k < int'(NUM_SBOX); k++) y[4*k +: 4] = g(x[4*k +: 4]);
        return y;
    endfunction

    function automatic logic [W-1:0] rand_w();
        return {$urandom, $urandom};
    endfunction

    task automatic new_rnd();
        for (int i = 0; i < 9; i++) rnd[32*i +: 32] = $urandom;
    endtask

    task automatic drive_x(input logic [W-1:0] x);
        in_sh0 = rand_w();
        in_sh1 = rand_w();
        in_sh2 = x ^ in_sh0 ^ in_sh1;
    endtask

    function automatic logic [W-1:0] unmask();
        return out_sh0 ^ out_sh1 ^ out_sh2;
    endfunction

    // One transfer through an otherwise idle pipe, checked against the model and a hand value for lane 0.
    task automatic send_check(input string name, input logic [W-1:0] s0, input logic [W-1:0] s1,
                              input logic [W-1:0] s2, input logic [3:0] exp0);
        logic [W-1:0] exp_y;
        exp_y = g_all(s0 ^ s1 ^ s2);
        in_sh0 = s0; in_sh1 = s1; in_sh2 = s2;
        in_valid = 1'b1; out_ready = 1'b1; new_rnd();
        @(negedge clk);
        in_valid = 1'b0; drive_x(rand_w()); new_rnd();
        repeat (LAT - 1) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid: got %b expected 1", name, out_valid); end
        checks++;
        if (unmask() !== exp_y) begin errors++; $display("FAIL %s value: got %h expected %h", name, unmask(), exp_y); end
        checks++;
        if (unmask()[3:0] !== exp0) begin errors++; $display("FAIL %s lane0: got %h expected %h", name, unmask()[3:0], exp0); end
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s drained: got out_valid %b expected 0", name, out_valid); end
        checks++;
        if (xfer_cnt !== exp_cnt) begin errors++; $display("FAIL %s xfer_cnt: got %0d expected %0d", name, xfer_cnt, exp_cnt); end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; drive_x(rand_w()); new_rnd();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++;
        if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL reset xfer_cnt: got %0d expected 0", xfer_cnt); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
        checks++;
        if ({out_sh0, out_sh1, out_sh2} !== '0) begin errors++; $display("FAIL reset shares: got %h %h %h expected 0", out_sh0, out_sh1, out_sh2); end
        rst = 1'b0; in_valid = 1'b0; exp_cnt = 16'd0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset release in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single();
        send_check("single", {16{4'h5}}, {16{4'hA}}, {16{4'hF}}, 4'h0);
    endtask

    task automatic test_vectors();
        send_check("vec_f", {16{4'h3}}, {16{4'h9}}, {16{4'h5}}, 4'h5);
        send_check("vec_6", {16{4'h1}}, {16{4'h2}}, {16{4'h5}}, 4'hF);
        send_check("vec_all", 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
                   64'h0123_4567_89AB_CDEF ^ 64'h1111_2222_3333_4444 ^ 64'hFEDC_BA98_7654_3210, 4'h0);
    endtask

    task automatic test_stall();
        logic [W-1:0] x, c0, c1, c2;
        logic         exp_rdy;
        x = rand_w();
        drive_x(x); in_valid = 1'b1; out_ready = 1'b0; new_rnd();
        @(negedge clk);
`ifdef SBOX_OUT_REG_EN
        in_valid = 1'b0; exp_rdy = 1'b1;
`else
        in_valid = 1'b1; exp_rdy = 1'b0;
`endif
        drive_x(rand_w()); new_rnd();
        repeat (LAT - 1) @(negedge clk);
        checks++;
        if (unmask() !== g_all(x)) begin errors++; $display("FAIL stall value: got %h expected %h", unmask(), g_all(x)); end
        c0 = out_sh0; c1 = out_sh1; c2 = out_sh2;
        for (int i = 0; i < 5; i++) begin
            drive_x(rand_w()); new_rnd();
            @(negedge clk);
            checks++;
            if ({out_sh0, out_sh1, out_sh2} !== {c0, c1, c2}) begin
                errors++; $display("FAIL stall hold %0d: got %h %h %h expected %h %h %h", i, out_sh0, out_sh1, out_sh2, c0, c1, c2);
            end
            checks++;
            if (out_valid !== 1'b1 || xfer_cnt !== exp_cnt) begin
                errors++; $display("FAIL stall state %0d: got valid %b cnt %0d expected 1 %0d", i, out_valid, xfer_cnt, exp_cnt);
            end
            checks++;
            if (in_ready !== exp_rdy) begin errors++; $display("FAIL stall in_ready %0d: got %b expected %b", i, in_ready, exp_rdy); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (xfer_cnt !== exp_cnt) begin errors++; $display("FAIL stall release cnt: got %0d expected %0d", xfer_cnt, exp_cnt); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall release valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_stall();
        drive_x(rand_w()); in_valid = 1'b1; out_ready = 1'b0; new_rnd();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall out_valid: got %b expected 0", out_valid); end
        checks++;
        if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall xfer_cnt: got %0d expected 0", xfer_cnt); end
        rst = 1'b0; exp_cnt = 16'd0;
        send_check("post_rst", {16{4'h3}}, {16{4'h9}}, {16{4'h5}}, 4'h5);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; exp_cnt = 16'd0;
        for (int i = 0; i < 1000 + LAT - 1; i++) begin
            if (i < 1000) begin
                x = rand_w(); drive_x(x); exp_tbl[i] = g_all(x); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1; new_rnd();
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready %0d: got %b expected 1", i, in_ready); end
            @(negedge clk);
            if (i >= LAT - 1) begin
                checks++;
                if (out_valid !== 1'b1 || unmask() !== exp_tbl[i-LAT+1]) begin
                    errors++; $display("FAIL b2b out %0d: got valid %b %h expected 1 %h", i-LAT+1, out_valid, unmask(), exp_tbl[i-LAT+1]);
                end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (xfer_cnt !== 16'd1000) begin errors++; $display("FAIL b2b xfer_cnt: got %0d expected 1000", xfer_cnt); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b tail valid: got %b expected 0", out_valid); end
        exp_cnt = 16'd1000;
    endtask

    // Two transfers against a stalled consumer: back-pressure, ordering and lossless replace on drain.
    task automatic test_fill();
        logic [W-1:0] xa, xb;
        xa = rand_w(); xb = rand_w();
        drive_x(xa); in_valid = 1'b1; out_ready = 1'b0; new_rnd();
        @(negedge clk);
`ifdef SBOX_OUT_REG_EN
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fill in_ready one: got %b expected 1", in_ready); end
        drive_x(xb); new_rnd();
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL fill in_ready full %0d: got %b expected 0", i, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || unmask() !== g_all(xa)) begin
                errors++; $display("FAIL fill first %0d: got %b %h expected 1 %h", i, out_valid, unmask(), g_all(xa));
            end
            new_rnd();
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
`else
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill in_ready full: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || unmask() !== g_all(xa)) begin
            errors++; $display("FAIL fill first: got %b %h expected 1 %h", out_valid, unmask(), g_all(xa));
        end
        drive_x(xb); new_rnd();
        @(negedge clk);
        checks++;
        if (unmask() !== g_all(xa)) begin errors++; $display("FAIL fill hold: got %h expected %h", unmask(), g_all(xa)); end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fill drain in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
`endif
        checks++;
        if (out_valid !== 1'b1 || unmask() !== g_all(xb)) begin
            errors++; $display("FAIL fill second: got %b %h expected 1 %h", out_valid, unmask(), g_all(xb));
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd2;
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== exp_cnt) begin
            errors++; $display("FAIL fill end: got valid %b cnt %0d expected 0 %0d", out_valid, xfer_cnt, exp_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; exp_cnt = 16'd0;
        in_sh0 = '0; in_sh1 = '0; in_sh2 = '0; rnd = '0;
        test_reset();
        test_single();
        test_vectors();
        test_stall();
        test_reset_stall();
        test_back_to_back();
        test_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_q2_masked_pipe.md
SBOX_Q2_MASKED_PIPE -- requirements
Module: sbox_q2_masked_pipe

Interface
REQ-001 SHALL have parameter NUM_SBOX, default 16, giving the number of parallel 4-bit S-box lanes (legal range 1..64).
REQ-002 SHALL have localparam RND_W = 18*NUM_SBOX, giving the fresh-randomness bits per accepted transfer.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the input shares and rnd are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-007 SHALL have ports in_sh0, in_sh1, in_sh2, input, 4*NUM_SBOX bits each: Boolean shares of the state; lane k occupies bits [4k+3:4k].
REQ-008 SHALL have port rnd, input, RND_W bits: fresh randomness; lane k uses bits [18k+17:18k].
REQ-009 SHALL have port out_valid, output, 1 bit: the output shares are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts output.
REQ-011 SHALL have ports out_sh0, out_sh1, out_sh2, output, 4*NUM_SBOX bits each: output shares, with the same lane layout as the inputs.
REQ-012 SHALL have port xfer_cnt, output, 16 bits: count of completed output transfers.

Function
REQ-013 The unshared lane function SHALL be G(x), with x = {d,c,b,a} and y = {y3,y2,y1,y0}: y0=c; y1=c^d; y2=a^(b&d)^c; y3=b^(c&d).
REQ-014 For every lane, out_sh0^out_sh1^out_sh2 SHALL equal G(in_sh0^in_sh1^in_sh2) of the transfer that produced it.
REQ-015 The nonlinear part SHALL be 18 component functions per lane (9 per quadratic output bit), each using at most 2 input shares plus rnd.
REQ-016 The 18 component-function outputs SHALL be registered before the 3-input XOR compression; compression SHALL never see unregistered terms.
REQ-017 The linear bits y0 and y1 SHALL be re-masked from lane rnd bits [17:16] and registered in the same stage, keeping 3 shares.
REQ-018 The 2nd-order probing security of the per-lane datapath SHALL hold with glitches under the register split of REQ-016.
REQ-019 Latency SHALL be 1 cycle from an accepted input (in_valid & in_ready) to out_valid.
REQ-020 in_ready SHALL be defined as !out_valid | out_ready, so the pipeline holds exactly one transfer.
REQ-021 On a stall (out_valid & !out_ready), all pipeline registers SHALL hold; rnd SHALL be ignored and not consumed.
REQ-022 Pipeline registers SHALL load only on an accepted input; no register SHALL load while in_valid=0.
REQ-023 Simultaneous output drain and input accept SHALL be lossless: out_valid stays 1 and new data replaces the old.
REQ-024 xfer_cnt SHALL increment on each out_valid & out_ready, wrapping from 0xFFFF to 0x0000.
REQ-025 Output shares SHALL be ignored while out_valid=0; their content is not specified.

Reset
REQ-026 While rst=1, out_valid=0, xfer_cnt=0, and all share registers SHALL be 0 on the next edge.
REQ-027 While rst=1, in_ready SHALL be 0 and inputs SHALL not be accepted.
REQ-028 Reset asserted mid-stall SHALL discard the held transfer; it SHALL not count in xfer_cnt.

Configuration
REQ-029 Macro SBOX_OUT_REG_EN, when defined, SHALL add a second register stage after compression.
REQ-030 With SBOX_OUT_REG_EN, latency SHALL be 2 cycles and up to 2 transfers SHALL be in flight.
REQ-031 With SBOX_OUT_REG_EN, each stage SHALL advance when its successor is empty or draining.
REQ-032 With SBOX_OUT_REG_EN, in_ready SHALL be !(stage1 full & stage2 full & !out_ready).
REQ-033 Without SBOX_OUT_REG_EN, latency SHALL be 1 cycle, the compression output SHALL drive out_sh* combinationally from registers, and REQ-019..023 apply.

Verification
REQ-034 NUM_SBOX=1, shares (0x5,0xA,0xF), random rnd, out_ready=1 -> next cycle out_valid=1, XOR of out shares = 0x0.
REQ-035 NUM_SBOX=1, x=0xF as (0x3,0x9,0x5) -> unshared out 0x5; x=0x6 -> 0xF.
REQ-036 Hold out_ready=0 for 5 cycles after one transfer, with rnd toggling -> out_sh* and xfer_cnt stable, in_ready=0; release -> xfer_cnt=1.
REQ-037 NUM_SBOX=16, 1000 back-to-back random transfers with out_ready=1 -> every lane matches G, xfer_cnt=1000, no bubbles.
REQ-038 Assert rst during a stall -> out_valid=0 and xfer_cnt=0 next cycle; first post-reset transfer is correct.
REQ-039 With SBOX_OUT_REG_EN, 2 transfers then out_ready=0 -> in_ready=0; both outputs are delivered in order.
